pipe_stage_reg: RTL and testbench
=================================

PIPE_STAGE_REG -- requirements
Module: pipe_stage_reg

Interface
REQ-001 SHALL have parameter CTRL_W, default 4, width of the stage control bundle (MemWrite, MemRead, RegWrite, MemToReg).
REQ-002 SHALL have parameter DATA_W, default 32, width of the ALU result and store-data fields.
REQ-003 SHALL have parameter DST_W, default 5, width of the destination register index.
REQ-004 SHALL have parameter CNT_W, default 16, width of the stall counter.
REQ-005 clk  input  1  clock; all state updates on the rising edge.
REQ-006 rst  input  1  reset, synchronous, active-high.
REQ-007 flush  input  1  discard all held and incoming entries.
REQ-008 in_valid  input  1  upstream entry present.
REQ-009 in_ready  output  1  stage can accept an entry this cycle.
REQ-010 in_ctrl / in_alu / in_wdata / in_dst  input  CTRL_W / DATA_W / DATA_W / DST_W  upstream payload.
REQ-011 out_valid  output  1  downstream entry present.
REQ-012 out_ready  input  1  downstream accepts the entry this cycle.
REQ-013 out_ctrl / out_alu / out_wdata / out_dst  output  CTRL_W / DATA_W / DATA_W / DST_W  registered payload.
REQ-014 stall_cnt  output  CNT_W  saturating count of back-pressured cycles.

Function
REQ-015 Accept SHALL occur when in_valid && in_ready && !flush; release SHALL occur when out_valid && out_ready.
REQ-016 Accepted entries SHALL leave in strict FIFO order; no entry SHALL be dropped or duplicated except by flush or rst.
REQ-017 Latency SHALL be 1 cycle: an entry accepted at edge N SHALL appear on out_* after edge N when the output register is empty or released at N.
REQ-018 Throughput SHALL be one entry per cycle while out_ready is held high.
REQ-019 While out_valid=0, out_ctrl SHALL be all-zero (bubble = NOP; no write enables), other out_* fields SHALL be zero.
REQ-020 out_* SHALL hold stable while out_valid=1 and out_ready=0.
REQ-021 flush=1 at an edge SHALL clear every held entry (out_valid=0, payload zero) and discard any simultaneous input; flush SHALL override accept and release.
REQ-022 stall_cnt SHALL increment by 1 on each edge where out_valid=1 and out_ready=0, saturate at all-ones, never wrap, and be unaffected by flush.
REQ-023 Simultaneous accept and release with one entry held SHALL replace the output entry with the new one in the same edge.

Reset
REQ-024 rst=1 at an edge SHALL clear out_valid, all out_* payload, all internal valid flags and stall_cnt to zero; rst SHALL override flush, accept and release.
REQ-025 Reset asserted mid-stall SHALL drop all held entries; in_ready SHALL be 1 on the first cycle after rst deasserts.

Configuration
REQ-026 Macro PIPE_STAGE_SKID_EN SHALL select the buffering mode.
REQ-027 With PIPE_STAGE_SKID_EN defined: a second (skid) entry SHALL be present; in_ready SHALL be a register output equal to !skid_valid, with no combinational path from out_ready; an entry accepted while the output is stalled SHALL go to the skid entry and move to the output on the release edge.
REQ-028 With PIPE_STAGE_SKID_EN undefined: single entry only; in_ready SHALL equal !out_valid || out_ready combinationally; capacity is 1.
REQ-029 REQ-015 to REQ-025 SHALL hold in both modes.

Verification
REQ-030 Stream in_alu=1..8, in_valid=1, out_ready=1 -> out_alu 1..8 on consecutive cycles, first one cycle after first accept, stall_cnt=0.
REQ-031 Skid mode: hold out_ready=0 for 3 cycles while offering in_alu=0xA,0xB,0xC -> 0xA held at output, 0xB in skid, in_ready=0 after second accept, stall_cnt=3; release -> 0xA,0xB,0xC in order.
REQ-032 No-skid mode: out_valid=1, out_ready=0 -> in_ready=0 same cycle; raise out_ready -> in_ready=1 same cycle, new entry replaces old at edge.
REQ-033 flush with output and skid full plus in_valid=1, in_ctrl=4'b1111 -> next cycle out_valid=0, out_ctrl=0, following cycle in_ready=1, flushed entries never appear.
REQ-034 Force 2^CNT_W+5 stalled cycles with CNT_W=4 -> stall_cnt sticks at 15; rst -> stall_cnt=0, out_valid=0.
REQ-035 Assert rst mid-stall with in_valid=1 -> all outputs zero after edge, no entry emitted after rst deasserts until a fresh accept.

Source files
------------

// File: rtl/pipe_stage_reg.sv
// rtl/pipe_stage_reg.sv - pipeline stage register with valid/ready handshake and stall counter.
// PIPE_STAGE_SKID_EN adds a skid entry so in_ready is registered.
module pipe_stage_reg #(
  parameter int CTRL_W = 4,
  parameter int DATA_W = 32,
  parameter int DST_W  = 5,
  parameter int CNT_W  = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              flush,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [CTRL_W-1:0] in_ctrl,
  input  logic [DATA_W-1:0] in_alu,
  input  logic [DATA_W-1:0] in_wdata,
  input  logic [DST_W-1:0]  in_dst,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [CTRL_W-1:0] out_ctrl,
  output logic [DATA_W-1:0] out_alu,
  output logic [DATA_W-1:0] out_wdata,
  output logic [DST_W-1:0]  out_dst,
  output logic [CNT_W-1:0]  stall_cnt
);

  localparam int ENT_W = CTRL_W + 2 * DATA_W + DST_W;

  logic [ENT_W-1:0] in_ent;
  logic [ENT_W-1:0] out_ent;
  logic             accept;
  logic             drain;

  assign in_ent = {in_ctrl, in_alu, in_wdata, in_dst};
  assign {out_ctrl, out_alu, out_wdata, out_dst} = out_ent;

  assign accept = in_valid && in_ready && !flush;
  assign drain  = out_valid && out_ready;

`ifdef PIPE_STAGE_SKID_EN
  logic             skid_valid;
  logic [ENT_W-1:0] skid_ent;

  // Skid only ever fills while the output is stalled, so in_ready never sees out_ready.
  assign in_ready = !skid_valid;

  always_ff @(posedge clk) begin
    if (rst || flush) begin
      out_valid  <= 1'b0;
      out_ent    <= '0;
      skid_valid <= 1'b0;
      skid_ent   <= '0;
    end else if (!out_valid || drain) begin
      if (skid_valid) begin
        out_valid  <= 1'b1;
        out_ent    <= skid_ent;
        skid_valid <= 1'b0;
        skid_ent   <= '0;
      end else if (accept) begin
        out_valid <= 1'b1;
        out_ent   <= in_ent;
      end else begin
        out_valid <= 1'b0;
        out_ent   <= '0;
      end
    end else if (accept) begin
      skid_valid <= 1'b1;
      skid_ent   <= in_ent;
    end
  end
`else
  assign in_ready = !out_valid || out_ready;

  always_ff @(posedge clk) begin
    if (rst || flush) begin
      out_valid <= 1'b0;
      out_ent   <= '0;
    end else if (accept) begin
      out_valid <= 1'b1;
      out_ent   <= in_ent;
    end else if (drain) begin
      out_valid <= 1'b0;
      out_ent   <= '0;
    end
  end
`endif

  // Flush deliberately does not touch the counter; only rst clears it.
  always_ff @(posedge clk) begin
    if (rst) begin
      stall_cnt <= '0;
    end else if (out_valid && !out_ready && (stall_cnt != {CNT_W{1'b1}})) begin
      stall_cnt <= stall_cnt + {{(CNT_W-1){1'b0}}, 1'b1};
    end
  end

endmodule

// File: tb/tb_pipe_stage_reg.sv
// tb/tb_pipe_stage_reg.sv - self-checking bench for pipe_stage_reg against a queue model.
module tb_pipe_stage_reg;
  localparam int CW = 4;
  localparam int DW = 32;
  localparam int XW = 5;
  localparam int NW = 4;

  typedef struct packed {
    logic [CW-1:0] ctrl;
    logic [DW-1:0] alu;
    logic [DW-1:0] wdata;
    logic [XW-1:0] dst;
  } ent_t;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          flush = 1'b0;
  logic          in_valid = 1'b0;
  logic          in_ready;
  logic [CW-1:0] in_ctrl = '0;
  logic [DW-1:0] in_alu = '0;
  logic [DW-1:0] in_wdata = '0;
  logic [XW-1:0] in_dst = '0;
  logic          out_valid;
  logic          out_ready = 1'b0;
  logic [CW-1:0] out_ctrl;
  logic [DW-1:0] out_alu;
  logic [DW-1:0] out_wdata;
  logic [XW-1:0] out_dst;
  logic [NW-1:0] stall_cnt;

  ent_t q[$];
  int   m_cnt = 0;
  int   n_checks = 0;
  int   n_pass = 0;

  pipe_stage_reg #(.CTRL_W(CW), .DATA_W(DW), .DST_W(XW), .CNT_W(NW)) dut (
    .clk(clk), .rst(rst), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_ctrl(in_ctrl), .in_alu(in_alu), .in_wdata(in_wdata), .in_dst(in_dst),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_ctrl(out_ctrl), .out_alu(out_alu), .out_wdata(out_wdata), .out_dst(out_dst),
    .stall_cnt(stall_cnt)
  );

  always #5 clk = ~clk;

  // Model: the stage is a FIFO of capacity 1 (plain) or 2 (skid).
  function automatic bit model_ready();
`ifdef PIPE_STAGE_SKID_EN
    return q.size() < 2;
`else
    return (q.size() == 0) || out_ready;
`endif
  endfunction

  function automatic ent_t model_out();
    ent_t e;
    e = '0;
    if (q.size() > 0) e = q[0];
    return e;
  endfunction

  task automatic step();
    bit   acc;
    bit   rel;
    ent_t e;
    acc = in_valid && model_ready() && !flush;
    rel = (q.size() > 0) && out_ready;
    e   = {in_ctrl, in_alu, in_wdata, in_dst};
    @(posedge clk);
    if (rst) begin
      q.delete();
      m_cnt = 0;
    end else begin
      if (q.size() > 0 && !out_ready && m_cnt < (1 << NW) - 1) m_cnt++;
      if (flush) q.delete();
      else begin
        if (rel) void'(q.pop_front());
        if (acc) q.push_back(e);
      end
    end
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
    step();
    rst = 1'b0;
  endtask

  task automatic test_reset();
    do_reset();
    n_checks++;
    if ({out_valid, out_ctrl, out_alu, out_wdata, out_dst, stall_cnt} !== '0)
      $display("FAIL reset_outputs: got %h want 0", {out_valid, out_ctrl, out_alu, out_wdata, out_dst, stall_cnt});
    else n_pass++;
    n_checks++;
    if (in_ready !== 1'b1) $display("FAIL reset_in_ready: got %b want 1", in_ready);
    else n_pass++;
  endtask

  task automatic test_stream();
    do_reset();
    out_ready = 1'b1; in_valid = 1'b1;
    for (int k = 1; k <= 8; k++) begin
      in_alu = k; in_wdata = $urandom; in_ctrl = CW'($urandom); in_dst = XW'($urandom);
      step();
      n_checks++;
      if (out_valid !== 1'b1 || out_alu !== DW'(k) || out_wdata !== model_out().wdata)
        $display("FAIL stream_%0d: got v=%b alu=%h want v=1 alu=%h", k, out_valid, out_alu, k);
      else n_pass++;
    end
    in_valid = 1'b0;
    step();
    n_checks++;
    if (out_valid !== 1'b0 || stall_cnt !== '0)
      $display("FAIL stream_end: got v=%b cnt=%0d want v=0 cnt=0", out_valid, stall_cnt);
    else n_pass++;
  endtask

`ifdef PIPE_STAGE_SKID_EN
  task automatic test_skid_stall();
    logic [DW-1:0] seen[$];
    bit acc;
    do_reset();
    in_valid = 1'b1; in_alu = 32'hA; step();
    in_alu = 32'hB; step();
    n_checks++;
    if (in_ready !== 1'b0 || out_alu !== 32'hA)
      $display("FAIL skid_full: got rdy=%b alu=%h want rdy=0 alu=a", in_ready, out_alu);
    else n_pass++;
    in_alu = 32'hC; step(); step();
    n_checks++;
    if (stall_cnt !== 4'd3 || out_alu !== 32'hA || stall_cnt !== NW'(m_cnt))
      $display("FAIL skid_stall_cnt: got cnt=%0d alu=%h want cnt=3 alu=a", stall_cnt, out_alu);
    else n_pass++;
    out_ready = 1'b1;
    for (int i = 0; i < 10; i++) begin
      if (out_valid) seen.push_back(out_alu);
      acc = in_valid && in_ready;
      step();
      if (acc) in_valid = 1'b0;
    end
    n_checks++;
    if (seen.size() != 3) $display("FAIL skid_order_len: got %0d want 3", seen.size());
    else if (seen[0] !== 32'hA || seen[1] !== 32'hB || seen[2] !== 32'hC)
      $display("FAIL skid_order: got %h %h %h want a b c", seen[0], seen[1], seen[2]);
    else n_pass++;
  endtask
`else
  task automatic test_noskid_stall();
    do_reset();
    in_valid = 1'b1; in_alu = 32'hA; step();
    in_alu = 32'hB; #1;
    n_checks++;
    if (in_ready !== 1'b0) $display("FAIL noskid_stalled_rdy: got %b want 0", in_ready);
    else n_pass++;
    out_ready = 1'b1; #1;
    n_checks++;
    if (in_ready !== 1'b1) $display("FAIL noskid_release_rdy: got %b want 1", in_ready);
    else n_pass++;
    step();
    n_checks++;
    if (out_valid !== 1'b1 || out_alu !== 32'hB)
      $display("FAIL noskid_replace: got v=%b alu=%h want v=1 alu=b", out_valid, out_alu);
    else n_pass++;
    in_valid = 1'b0; step();
  endtask
`endif

  task automatic test_flush();
    bit leak;
    do_reset();
    in_valid = 1'b1; in_ctrl = 4'b0101; in_alu = 32'h11; step();
    in_alu = 32'h22; step();
    in_ctrl = 4'b1111; in_alu = 32'h33; flush = 1'b1; step();
    n_checks++;
    if (out_valid !== 1'b0 || out_ctrl !== 4'b0000 || out_alu !== '0)
      $display("FAIL flush_clear: got v=%b ctrl=%b alu=%h want 0", out_valid, out_ctrl, out_alu);
    else n_pass++;
    flush = 1'b0; in_valid = 1'b0; step();
    n_checks++;
    if (in_ready !== 1'b1) $display("FAIL flush_ready: got %b want 1", in_ready);
    else n_pass++;
    out_ready = 1'b1; leak = 1'b0;
    for (int i = 0; i < 4; i++) begin
      step();
      if (out_valid !== 1'b0) leak = 1'b1;
    end
    n_checks++;
    if (leak) $display("FAIL flush_leak: got out_valid=1 after flush want 0");
    else n_pass++;
  endtask

  task automatic test_saturate();
    do_reset();
    in_valid = 1'b1; in_alu = 32'h5; step();
    in_valid = 1'b0;
    for (int i = 0; i < (1 << NW) + 5; i++) step();
    n_checks++;
    if (stall_cnt !== 4'hF) $display("FAIL sat_cnt: got %0d want 15", stall_cnt);
    else n_pass++;
    rst = 1'b1; step(); rst = 1'b0;
    n_checks++;
    if (stall_cnt !== '0 || out_valid !== 1'b0)
      $display("FAIL sat_reset: got cnt=%0d v=%b want 0 0", stall_cnt, out_valid);
    else n_pass++;
  endtask

  task automatic test_reset_mid_stall();
    bit leak;
    do_reset();
    in_valid = 1'b1; in_alu = 32'h1; step();
    in_alu = 32'h2; step(); step();
    in_alu = 32'h3; rst = 1'b1; step();
    n_checks++;
    if ({out_valid, out_ctrl, out_alu, out_wdata, out_dst, stall_cnt} !== '0)
      $display("FAIL midrst_outputs: got %h want 0", {out_valid, out_ctrl, out_alu, out_wdata, out_dst, stall_cnt});
    else n_pass++;
    rst = 1'b0; in_valid = 1'b0; out_ready = 1'b1; #1;
    n_checks++;
    if (in_ready !== 1'b1) $display("FAIL midrst_ready: got %b want 1", in_ready);
    else n_pass++;
    leak = 1'b0;
    for (int i = 0; i < 4; i++) begin
      step();
      if (out_valid !== 1'b0) leak = 1'b1;
    end
    n_checks++;
    if (leak) $display("FAIL midrst_leak: got out_valid=1 want 0");
    else n_pass++;
    in_valid = 1'b1; in_alu = 32'h44; step();
    in_valid = 1'b0;
    n_checks++;
    if (out_valid !== 1'b1 || out_alu !== 32'h44)
      $display("FAIL midrst_fresh: got v=%b alu=%h want v=1 alu=44", out_valid, out_alu);
    else n_pass++;
  endtask

  task automatic test_random();
    logic [CW+2*DW+XW+NW+1:0] got;
    logic [CW+2*DW+XW+NW+1:0] want;
    do_reset();
    for (int i = 0; i < 600; i++) begin
      in_valid  = ($urandom_range(99, 0) < 65);
      out_ready = ($urandom_range(99, 0) < 60);
      flush     = ($urandom_range(99, 0) < 4);
      rst       = ($urandom_range(199, 0) < 2);
      in_ctrl   = CW'($urandom);
      in_alu    = $urandom;
      in_wdata  = $urandom;
      in_dst    = XW'($urandom);
      #1;
      got  = {out_valid, out_ctrl, out_alu, out_wdata, out_dst, stall_cnt, in_ready};
      want = {q.size() > 0, model_out(), NW'(m_cnt), model_ready()};
      n_checks++;
      if (got !== want) $display("FAIL random_%0d: got %h want %h", i, got, want);
      else n_pass++;
      step();
    end
    rst = 1'b0; flush = 1'b0; in_valid = 1'b0;
  endtask

  initial begin
    test_reset();
    test_stream();
`ifdef PIPE_STAGE_SKID_EN
    test_skid_stall();
`else
    test_noskid_stall();
`endif
    test_flush();
    test_saturate();
    test_reset_mid_stall();
    test_random();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
